// File: rtl/data_cmp_pkg.sv
// Shared types and result decode for the iterative operand comparator.
package data_cmp_pkg;

  typedef enum logic [2:0] {
    CMP_EQ  = 3'd0,
    CMP_NE  = 3'd1,
    CMP_LT  = 3'd2,
    CMP_GE  = 3'd3,
    CMP_LTU = 3'd4,
    CMP_GEU = 3'd5,
    CMP_EQZ = 3'd6,
    CMP_NEZ = 3'd7
  } cmp_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } cmp_state_e;

  function automatic logic cmp_is_signed(cmp_mode_e mode);
    return (mode == CMP_LT) || (mode == CMP_GE);
  endfunction

  function automatic logic cmp_is_zero(cmp_mode_e mode);
    return (mode == CMP_EQZ) || (mode == CMP_NEZ);
  endfunction

  // lt is only meaningful when eq is clear; the decode masks it accordingly.
  function automatic logic cmp_decode(cmp_mode_e mode, logic eq, logic lt);
    logic res;
    res = 1'b0;
    case (mode)
      CMP_EQ, CMP_EQZ:  res = eq;
      CMP_NE, CMP_NEZ:  res = ~eq;
      CMP_LT, CMP_LTU:  res = lt & ~eq;
      CMP_GE, CMP_GEU:  res = ~lt | eq;
      default:          res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/data_cmp_slice.sv
// One CHUNK-bit magnitude compare; flip inverts both MSBs so a signed slice orders correctly.
module data_cmp_slice #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             flip,
  output logic             eq,
  output logic             lt
);

  logic [CHUNK-1:0] msk, a_x, b_x;

  assign msk = CHUNK'(flip) << (CHUNK - 1);
  assign a_x = a ^ msk;
  assign b_x = b ^ msk;
  assign eq  = (a_x == b_x);
  assign lt  = (a_x < b_x);

endmodule

// File: rtl/data_compare_unit.sv
// Iterative MSB-first operand comparator with valid/ready handshake.
// Optional shadow checker enabled by defining DATA_CMP_DMR_EN.
module data_compare_unit
  import data_cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CLR,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       MODE,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             COMP_OUT,
  output logic             CMP_ERR
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  generate
    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
      $error("data_compare_unit: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  cmp_state_e       state, state_nxt;
  cmp_mode_e        mode_r;
  logic [WIDTH-1:0] a_r, b_r;
  logic [CNT_W-1:0] cnt;
  logic             decided, lt_r, eq_r;
  logic             accept, last, flip, s_eq, s_lt, fin_decided, fin_lt;
  logic [IDX_W-1:0] sl_lo;
  logic [CHUNK-1:0] a_sl, b_sl;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    IN_READY  = 1'b0;
    OUT_VALID = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        IN_READY = 1'b1;
        if (IN_VALID && !CLR) begin
          accept    = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: if (last) state_nxt = DONE;
      DONE: begin
        OUT_VALID = 1'b1;
        if (OUT_READY) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (CLR) state_nxt = IDLE;
  end

  // Slice 0 is the MSB slice; only it carries the sign.
  assign last  = (cnt == CNT_W'(N - 1));
  assign flip  = (cnt == '0) && cmp_is_signed(mode_r);
  assign sl_lo = IDX_W'((N - 1 - int'(cnt)) * CHUNK);
  assign a_sl  = a_r[sl_lo +: CHUNK];
  assign b_sl  = b_r[sl_lo +: CHUNK];

  data_cmp_slice #(.CHUNK(CHUNK)) u_slice (
    .a    (a_sl),
    .b    (b_sl),
    .flip (flip),
    .eq   (s_eq),
    .lt   (s_lt)
  );

  // The first differing slice decides; later slices cannot change the outcome.
  assign fin_decided = decided | ~s_eq;
  assign fin_lt      = decided ? lt_r : s_lt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      a_r <= '0; b_r <= '0; mode_r <= CMP_EQ;
      cnt <= '0; decided <= 1'b0; lt_r <= 1'b0; eq_r <= 1'b0;
    end else if (CLR) begin
      cnt <= '0; decided <= 1'b0; lt_r <= 1'b0; eq_r <= 1'b0;
    end else if (accept) begin
      a_r     <= A;
      b_r     <= cmp_is_zero(cmp_mode_e'(MODE)) ? '0 : B;
      mode_r  <= cmp_mode_e'(MODE);
      cnt     <= '0;
      decided <= 1'b0;
      lt_r    <= 1'b0;
      eq_r    <= 1'b0;
    end else if (state == BUSY) begin
      cnt     <= last ? '0 : cnt + 1'b1;
      decided <= fin_decided;
      lt_r    <= fin_lt;
      if (last) eq_r <= ~fin_decided;
    end
  end

  assign COMP_OUT = (state == DONE) & cmp_decode(mode_r, eq_r, lt_r);

`ifdef DATA_CMP_DMR_EN
  logic sh_lt, sh_res, it_res, err_r;

  assign sh_lt  = cmp_is_signed(mode_r) ? ($signed(a_r) < $signed(b_r)) : (a_r < b_r);
  assign sh_res = cmp_decode(mode_r, a_r == b_r, sh_lt);
  assign it_res = cmp_decode(mode_r, ~fin_decided, fin_lt);

  // Sticky until reset; abort does not clear a detected fault.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) err_r <= 1'b0;
    else if (state == BUSY && last && !CLR && sh_res != it_res) err_r <= 1'b1;
  end

  assign CMP_ERR = err_r;
`else
  assign CMP_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_data_compare_unit.sv
// Randomized + directed bench for data_compare_unit against a full-width reference model.
module tb_data_compare_unit;
  import data_cmp_pkg::*;

  localparam int W = 32;
  localparam int N = 4;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          CLR = 1'b0;
  logic          IN_VALID = 1'b0;
  logic          IN_READY;
  logic [W-1:0]  A = '0;
  logic [W-1:0]  B = '0;
  logic [2:0]    MODE = 3'd0;
  logic          OUT_VALID;
  logic          OUT_READY = 1'b1;
  logic          COMP_OUT;
  logic          CMP_ERR;

  int vectors = 0;
  int miscompares = 0;
  bit mask_chk = 1'b0;
  bit exp_err = 1'b0;

  data_compare_unit #(.WIDTH(W), .CHUNK(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .CLR(CLR), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .A(A), .B(B), .MODE(MODE), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .COMP_OUT(COMP_OUT), .CMP_ERR(CMP_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit ref_cmp(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] m);
    logic [W-1:0] bb;
    bit eq, lts, ltu, r;
    bb  = (m >= 3'd6) ? '0 : b;
    eq  = (a == bb);
    lts = ($signed(a) < $signed(bb));
    ltu = (a < bb);
    case (m)
      3'd0, 3'd6: r = eq;
      3'd1, 3'd7: r = !eq;
      3'd2:       r = lts;
      3'd3:       r = !lts;
      3'd4:       r = ltu;
      default:    r = !ltu;
    endcase
    return r;
  endfunction

  // Reference: a request occupies N cycles, then its result waits for the consumer.
  int m_left = 0;
  bit m_have = 1'b0;
  bit m_res  = 1'b0;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_left = 0; m_have = 1'b0; m_res = 1'b0;
    end else if (CLR) begin
      m_left = 0; m_have = 1'b0;
    end else if (m_have) begin
      if (OUT_READY) m_have = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) m_have = 1'b1;
    end else if (IN_VALID) begin
      m_left = N;
      m_res  = ref_cmp(A, B, MODE);
    end
  end

  always @(negedge CLK) begin
    chk("in_ready", IN_READY, (!m_have && m_left == 0));
    chk("out_valid", OUT_VALID, m_have);
    if (!mask_chk) begin
      chk("comp_out", COMP_OUT, m_have & m_res);
      chk("cmp_err", CMP_ERR, exp_err);
    end
  end

  task automatic wait_ready();
    int c = 0;
    @(negedge CLK);
    while (!IN_READY && c < 50) begin @(negedge CLK); c++; end
    if (!IN_READY) chk("ready_timeout", 0, 1);
  endtask

  task automatic req(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] m,
                     input bit exp, input int hold);
    int cyc;
    wait_ready();
    OUT_READY = (hold == 0);
    IN_VALID = 1'b1; A = a; B = b; MODE = m;
    @(negedge CLK);
    IN_VALID = 1'b0;
    cyc = 1;
    while (!OUT_VALID && cyc < 50) begin @(negedge CLK); cyc++; end
    chk("latency", cyc - 1, N);
    chk("result", COMP_OUT, exp);
    for (int k = 0; k < hold; k++) begin
      @(negedge CLK);
      chk("hold_valid", OUT_VALID, 1);
      chk("hold_result", COMP_OUT, exp);
      chk("hold_in_ready", IN_READY, 0);
    end
    OUT_READY = 1'b1;
    @(negedge CLK);
    chk("post_handshake", OUT_VALID, 0);
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    chk("rst_in_ready", IN_READY, 1);
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_comp_out", COMP_OUT, 0);
    chk("rst_cmp_err", CMP_ERR, 0);
    RST_N = 1'b1;

    req(32'hFFFF_FFFF, 32'h0000_0001, CMP_LT,  1'b1, 0);
    req(32'hFFFF_FFFF, 32'h0000_0001, CMP_LTU, 1'b0, 0);
    req(32'h0000_0000, 32'h1234_5678, CMP_EQZ, 1'b1, 0);
    req(32'h0000_0100, 32'h0000_0000, CMP_NEZ, 1'b1, 0);
    req(32'h8000_0000, 32'h8000_0000, CMP_GE,  1'b1, 0);
    req(32'h8000_0000, 32'h8000_0000, CMP_NE,  1'b0, 0);

    // Backpressure, with a second request already waiting.
    wait_ready();
    OUT_READY = 1'b0;
    IN_VALID = 1'b1; A = 32'd5; B = 32'd9; MODE = CMP_LTU;
    @(negedge CLK);
    A = 32'd3; B = 32'd3; MODE = CMP_EQ;
    repeat (N) @(negedge CLK);
    for (int k = 0; k < 3; k++) begin
      chk("bp_valid", OUT_VALID, 1);
      chk("bp_result", COMP_OUT, 1);
      chk("bp_in_ready", IN_READY, 0);
      @(negedge CLK);
    end
    chk("bp_last_valid", OUT_VALID, 1);
    OUT_READY = 1'b1;
    @(negedge CLK);
    chk("bp_idle_after_hs", IN_READY, 1);
    @(negedge CLK);
    chk("bp_second_accepted", IN_READY, 0);
    IN_VALID = 1'b0;
    repeat (N + 2) @(negedge CLK);

    // Abort in the second BUSY cycle.
    wait_ready();
    IN_VALID = 1'b1; A = 32'd1; B = 32'd2; MODE = CMP_LTU;
    @(negedge CLK);
    IN_VALID = 1'b0;
    @(negedge CLK);
    CLR = 1'b1; IN_VALID = 1'b1;
    @(negedge CLK);
    CLR = 1'b0; IN_VALID = 1'b0;
    chk("clr_in_ready", IN_READY, 1);
    chk("clr_out_valid", OUT_VALID, 0);
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      chk("clr_no_result", OUT_VALID, 0);
    end
    req(32'd3, 32'd3, CMP_EQ, 1'b1, 0);

    // Asynchronous reset mid-BUSY.
    wait_ready();
    IN_VALID = 1'b1; A = 32'd7; B = 32'd7; MODE = CMP_EQ;
    @(negedge CLK);
    IN_VALID = 1'b0;
    @(posedge CLK);
    #2 RST_N = 1'b0;
    #1;
    chk("arst_in_ready", IN_READY, 1);
    chk("arst_out_valid", OUT_VALID, 0);
    chk("arst_comp_out", COMP_OUT, 0);
    chk("arst_cmp_err", CMP_ERR, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    req(32'h7FFF_FFFF, 32'h8000_0000, CMP_GE, 1'b1, 0);

    // Random traffic with random backpressure and occasional aborts.
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      IN_VALID  = $urandom_range(0, 1);
      A         = $urandom;
      case ($urandom_range(0, 3))
        0:       B = A;
        1:       B = A ^ (32'h1 << $urandom_range(0, 31));
        default: B = $urandom;
      endcase
      MODE      = 3'($urandom_range(0, 7));
      OUT_READY = ($urandom_range(0, 3) != 0);
      CLR       = ($urandom_range(0, 49) == 0);
    end
    @(negedge CLK);
    IN_VALID = 1'b0; CLR = 1'b0; OUT_READY = 1'b1;
    repeat (N + 3) @(negedge CLK);

`ifdef DATA_CMP_DMR_EN
    begin
      int c;
      wait_ready();
      mask_chk = 1'b1;
      force dut.u_slice.lt = 1'b0;
      IN_VALID = 1'b1; A = 32'd5; B = 32'd9; MODE = CMP_LT;
      @(negedge CLK);
      IN_VALID = 1'b0;
      c = 0;
      while (!OUT_VALID && c < 50) begin @(negedge CLK); c++; end
      chk("dmr_err_set", CMP_ERR, 1);
      release dut.u_slice.lt;
      @(negedge CLK);
      exp_err = 1'b1;
      mask_chk = 1'b0;
      CLR = 1'b1;
      @(negedge CLK);
      CLR = 1'b0;
      chk("dmr_err_after_clr", CMP_ERR, 1);
      req(32'd3, 32'd4, CMP_LTU, 1'b1, 0);
      chk("dmr_err_sticky", CMP_ERR, 1);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
